// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display encode/decode blocks.
//   SEG_HEX   : active-low gfedcba code for each hex digit 0..F
//   SEG_BLANK : all segments off
//   NIBBLE_W  : width of one recovered hex digit
//   seg_dec_t : result of decoding one 7-bit segment pattern
package seg7_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [NIBBLE_W-1:0] nibble;
        logic                blank;
        logic                err;
    } seg_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low 7-segment pattern.
//   pattern : segment lines, active-low, bit0=a ... bit6=g
//   result  : {nibble, blank, err}; blank for all-off, err for any
//             pattern that is not a hex glyph (nibble forced to 0 for both)
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   result
);

    always_comb begin
        result     = '0;
        result.err = 1'b1;
        if (pattern == SEG_BLANK) begin
            result.err   = 1'b0;
            result.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == SEG_HEX[i]) begin
                    result.nibble = NIBBLE_W'(i);
                    result.err    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex value on each digit of a multiplexed active-low
// 7-segment display bus and presents complete frames on valid/ready.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   seg_n       : segment lines, active-low, bit0=a ... bit6=g
//   an_n        : digit strobes, active-low, bit i = digit i
//   frame_ready : consumer accepts the frame
//   frame_valid : frame available
//   frame_hex   : nibble i at bits [4i+3:4i]
//   frame_blank : digit i showed all segments off
//   frame_err   : digit i showed a non-hex pattern
//   overrun     : sticky, a pending frame was modified before acceptance
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [6:0]                   seg_n,
    input  logic [DIGITS-1:0]            an_n,
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [NIBBLE_W*DIGITS-1:0]   frame_hex,
    output logic [DIGITS-1:0]            frame_blank,
    output logic [DIGITS-1:0]            frame_err,
    output logic                         overrun
);

    localparam int CNT_W = $clog2(STABLE + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Input stage
    logic [6:0]        s_seg;
    logic [DIGITS-1:0] s_an;

    // Stability tracking
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  prev_idx_reg;
    logic [6:0]        prev_seg_reg;
    logic              prev_valid_reg;

    // Frame assembly
    logic [DIGITS-1:0] seen_reg, seen_next;
    logic [0:0]        state_reg;

    logic [DIGITS-1:0] an_low;
    logic              an_one;
    logic [IDX_W-1:0]  idx;
    logic              changed;
    logic              capture;
    logic              seen_full;
    logic              transfer;
    logic              overrun_set;
    seg_dec_t          dec;

    logic [NIBBLE_W*DIGITS-1:0] shadow_hex;
    logic [DIGITS-1:0]          shadow_blank;
    logic [DIGITS-1:0]          shadow_err;

    seg7_pattern_decode u_decode (
        .pattern (s_seg),
        .result  (dec)
    );

    // A strobe is usable only when exactly one digit line is low.
    always_comb begin
        an_low = ~s_an;
        an_one = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    // The counter restarts whenever the (digit, pattern) pair differs from
    // the previous cycle; capture fires on the edge where it reaches STABLE,
    // and the saturation check keeps it to one capture per stable period.
    always_comb begin
        changed = !prev_valid_reg || (idx != prev_idx_reg) || (s_seg != prev_seg_reg);
        if (!an_one) begin
            cnt_next = '0;
        end else if (changed) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else begin
            cnt_next = cnt_reg;
        end
        capture = an_one && (cnt_next == CNT_MAX) && (changed || (cnt_reg != CNT_MAX));
    end

    // A transfer copies the shadow out; a capture on the same edge lands
    // after the clear so its slot remains marked for the next frame.
    always_comb begin
        seen_full   = &seen_reg;
        transfer    = seen_full && ((state_reg == ST_EMPTY) || frame_ready);
        overrun_set = capture && seen_full && frame_valid && !frame_ready;
        seen_next   = transfer ? '0 : seen_reg;
        if (capture) begin
            seen_next[idx] = 1'b1;
        end
    end

    // One shadow slot per digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
        seg_dec_t slot_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                slot_reg <= '0;
            end else if (capture && (idx == IDX_W'(gi))) begin
                slot_reg <= dec;
            end
        end

        assign shadow_hex[gi*NIBBLE_W +: NIBBLE_W] = slot_reg.nibble;
        assign shadow_blank[gi]                    = slot_reg.blank;
        assign shadow_err[gi]                      = slot_reg.err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg          <= '0;
            s_an           <= '0;
            cnt_reg        <= '0;
            prev_idx_reg   <= '0;
            prev_seg_reg   <= '0;
            prev_valid_reg <= 1'b0;
            seen_reg       <= '0;
            state_reg      <= ST_EMPTY;
            frame_valid    <= 1'b0;
            frame_hex      <= '0;
            frame_blank    <= '0;
            frame_err      <= '0;
            overrun        <= 1'b0;
        end else begin
            s_seg          <= seg_n;
            s_an           <= an_n;
            cnt_reg        <= cnt_next;
            prev_idx_reg   <= idx;
            prev_seg_reg   <= s_seg;
            prev_valid_reg <= an_one;
            seen_reg       <= seen_next;

            if (overrun_set) begin
                overrun <= 1'b1;
            end

            if (transfer) begin
                frame_hex   <= shadow_hex;
                frame_blank <= shadow_blank;
                frame_err   <= shadow_err;
                frame_valid <= 1'b1;
                state_reg   <= ST_FULL;
            end else if ((state_reg == ST_FULL) && frame_ready) begin
                frame_valid <= 1'b0;
                state_reg   <= ST_EMPTY;
            end
        end
    end

endmodule
